aidan_mcnay_prime_feeder: RTL and testbench

On-chip stimulus stage that drives the prime detector's user-facing serial port in place of a human or external MCU. Given a base value and a candidate count, it serially shifts each consecutive candidate over SDI/SCLK/CS, pulses ready, waits for done, and tallies is_prime results. It sits directly upstream of the detector: its outputs connect to the detector's SDI, SCLK, CS and ready inputs, and it consumes the detector's done and is_prime outputs.

---
 rtl/aidan_mcnay_feeder_pkg.sv | 24 ++
 rtl/aidan_mcnay_piso.sv | 24 ++
 rtl/aidan_mcnay_prime_feeder.sv | 138 +++++++++++++
 tb/tb_aidan_mcnay_prime_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aidan_mcnay_feeder_pkg.sv
// Shared definitions for the prime feeder: FSM encoding and timing defaults.
package aidan_mcnay_feeder_pkg;

  localparam int HALF_PERIOD_DEF  = 16;
  localparam int READY_CYCLES_DEF = 4;

  // Nine states are needed, so the encoding is one bit wider than eight would allow.
  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_RELEASE,
    S_READY,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aidan_mcnay_piso.sv
// Parallel-load, MSB-first shift register; the transmit-side twin of the detector's SIPO.
module aidan_mcnay_piso #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [nbits-1:0] data,
  output logic             serial
);

  logic [nbits-1:0] sr;

  // Load wins over shift; shifting moves the next bit into the MSB slot.
  always_ff @(posedge clk) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= data;
    else if (shift) sr <= sr << 1;
  end

  assign serial = sr[nbits-1];

endmodule

// File: rtl/aidan_mcnay_prime_feeder.sv
// Stimulus stage that serially feeds consecutive candidates to the prime
// detector and tallies the verdicts it returns.
module aidan_mcnay_prime_feeder
  import aidan_mcnay_feeder_pkg::*;
#(
  parameter int nbits        = 32,
  parameter int HALF_PERIOD  = HALF_PERIOD_DEF,
  parameter int READY_CYCLES = READY_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [nbits-1:0] base,
  input  logic [7:0]       num,
  output logic             sdi,
  output logic             sclk,
  output logic             cs,
  output logic             ready,
  input  logic             done,
  input  logic             is_prime,
  output logic             busy,
  output logic             finished,
  output logic [7:0]       prime_count,
  output logic [nbits-1:0] last_prime
);

  localparam int PW = (max2(HALF_PERIOD, READY_CYCLES) > 1) ?
                      $clog2(max2(HALF_PERIOD, READY_CYCLES)) : 1;
  localparam int BW = (nbits > 1) ? $clog2(nbits) : 1;

  localparam logic [PW-1:0] HP_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] RC_LAST  = PW'(READY_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(nbits - 1);

  state_t           state, next_state;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bit_idx;
  logic [nbits-1:0] cand;
  logic [7:0]       remaining;
  logic             piso_load, piso_shift, piso_bit;

  aidan_mcnay_piso #(.nbits(nbits)) u_piso (
    .clk    (clk),
    .reset  (reset),
    .load   (piso_load),
    .shift  (piso_shift),
    .data   (cand),
    .serial (piso_bit)
  );

  // Next-state logic; the PISO is shifted as SHIFT_LO ends, after sdi has
  // already captured the current bit, so the next bit is ready for the next low phase.
  always_comb begin
    next_state = state;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state)
      S_IDLE:      if (start) next_state = (num == 8'd0) ? S_FINISH : S_SETUP;
      S_SETUP: begin
        piso_load = 1'b1;
        if (phase == HP_LAST) next_state = S_SHIFT_LO;
      end
      S_SHIFT_LO:  if (phase == HP_LAST) begin
        next_state = S_SHIFT_HI;
        piso_shift = 1'b1;
      end
      S_SHIFT_HI:  if (phase == HP_LAST)
                     next_state = (bit_idx == BIT_LAST) ? S_RELEASE : S_SHIFT_LO;
      S_RELEASE:   if (phase == HP_LAST) next_state = S_READY;
      S_READY:     if (phase == RC_LAST) next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (done) next_state = S_NEXT;
      S_NEXT:      next_state = (remaining == 8'd1) ? S_FINISH : S_SETUP;
      S_FINISH:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // State register plus phase and bit counters; phase restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state <= next_state;
      phase <= (next_state != state) ? '0 : phase + PW'(1);
      if (state == S_SETUP)
        bit_idx <= '0;
      else if (state == S_SHIFT_HI && next_state != S_SHIFT_HI)
        bit_idx <= bit_idx + BW'(1);
    end
  end

  // Run datapath: candidate, remaining count and the prime tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand        <= '0;
      remaining   <= '0;
      prime_count <= '0;
      last_prime  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cand        <= base;
        remaining   <= num;
        prime_count <= '0;
      end
      // Only one WAIT_DONE cycle can see done, so a level held high counts once.
      if (state == S_WAIT_DONE && done && is_prime) begin
        if (prime_count != 8'hFF) prime_count <= prime_count + 8'd1;
        last_prime <= cand;
      end
      if (state == S_NEXT) begin
        cand      <= cand + nbits'(1);
        remaining <= remaining - 8'd1;
      end
    end
  end

  // Registered outputs derived from the upcoming state so they line up with state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      sdi      <= 1'b0;
      sclk     <= 1'b0;
      cs       <= 1'b1;
      ready    <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      if (next_state == S_SHIFT_LO && state != S_SHIFT_LO) sdi <= piso_bit;
      sclk     <= (next_state == S_SHIFT_HI);
      cs       <= !(next_state inside {S_SETUP, S_SHIFT_LO, S_SHIFT_HI});
      ready    <= (next_state == S_READY);
      busy     <= (next_state != S_IDLE);
      finished <= (state == S_FINISH);
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_feeder.sv
// Scoreboard bench for the prime feeder with a behavioural detector model.
module tb_aidan_mcnay_prime_feeder;

  localparam int NB = 8;
  localparam int HP = 2;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          reset, start, done, is_prime;
  logic [NB-1:0] base;
  logic [7:0]    num;
  logic          sdi, sclk, cs, ready, busy, finished;
  logic [7:0]    prime_count;
  logic [NB-1:0] last_prime;

  always #5 clk = ~clk;

  aidan_mcnay_prime_feeder #(.nbits(NB), .HALF_PERIOD(HP), .READY_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .num(num),
    .sdi(sdi), .sclk(sclk), .cs(cs), .ready(ready), .done(done),
    .is_prime(is_prime), .busy(busy), .finished(finished),
    .prime_count(prime_count), .last_prime(last_prime)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit prime_f(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: the candidate stream and per-run results a run should produce.
  typedef struct { int cnt; int lastp; } res_t;
  logic [NB-1:0] cand_q[$];
  res_t          res_q[$];
  int            model_last = 0;

  task automatic expect_run(input int b, input int n);
    int cnt;
    res_t r;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      int c;
      c = (b + i) % 256;
      cand_q.push_back(NB'(c));
      if (prime_f(c)) begin
        if (cnt < 255) cnt++;
        model_last = c;
      end
    end
    r.cnt = cnt;
    r.lastp = model_last;
    res_q.push_back(r);
  endtask

  // Detector model: shift in sdi on sclk rise, answer 5 cycles after ready falls.
  logic [NB-1:0] dword = '0;
  logic d_sclk = 1'b0, d_cs = 1'b1, d_ready = 1'b0;
  int   cd = 0;
  initial begin
    done = 1'b0;
    is_prime = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done = 1'b0; cd = 0;
      end else begin
        if (d_cs && !cs) done = 1'b0;
        if (!d_sclk && sclk && !cs) dword = {dword[NB-2:0], sdi};
        if (d_ready && !ready) cd = 5;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            done = 1'b1;
            is_prime = prime_f(int'(dword));
          end
        end
      end
      d_sclk = sclk; d_cs = cs; d_ready = ready;
    end
  end

  // Monitor: decodes each word on the wire and checks it against the queues.
  logic [NB-1:0] rx = '0;
  logic [NB-1:0] exp_w;
  res_t          exp_r;
  int   rx_bits = 0, mon_words = 0, fin_cnt = 0, rdy_len = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rdy_len = 0;
      end else begin
        if (p_cs && !cs) begin rx = '0; rx_bits = 0; end
        if (!p_sclk && sclk) begin
          chk("cs_low_at_sclk_rise", 32'(cs), 32'd0);
          rx = {rx[NB-2:0], sdi};
          rx_bits++;
        end
        if (!p_cs && cs) begin
          if (cand_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_word: got 0x%0h, want no word", rx);
          end else begin
            exp_w = cand_q.pop_front();
            chk("word", 32'(rx), 32'(exp_w));
            chk("sclk_rises", rx_bits, NB);
          end
          mon_words++;
        end
        if (ready && !p_ready) chk("cs_high_at_ready", 32'(cs), 32'd1);
        if (ready) rdy_len++;
        if (!ready && p_ready) begin
          chk("ready_len", rdy_len, RC);
          rdy_len = 0;
        end
        if (finished) begin
          fin_cnt++;
          if (res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_finished: got pulse, want none");
          end else begin
            exp_r = res_q.pop_front();
            chk("prime_count", 32'(prime_count), exp_r.cnt);
            chk("last_prime", 32'(last_prime), exp_r.lastp);
            chk("busy_at_finish", 32'(busy), 32'd0);
          end
        end
      end
      p_sclk = sclk; p_cs = cs; p_ready = ready;
    end
  end

  task automatic wait_finish(input int f0, input int bound);
    int k;
    k = 0;
    while (fin_cnt == f0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (fin_cnt == f0) begin
      vectors++; miscompares++;
      $display("FAIL finish_timeout: got no finished, want pulse within %0d cycles", bound);
    end
  endtask

  task automatic run(input int b, input int n, input bit extra);
    int f0;
    expect_run(b, n);
    @(negedge clk);
    f0 = fin_cnt;
    base = NB'(b); num = 8'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; base = NB'($urandom); num = 8'($urandom);
    if (extra) begin
      repeat (30) @(negedge clk);
      chk("busy_mid_run", 32'(busy), 32'd1);
      start = 1'b1; base = NB'(b + 100); num = 8'd7;
      @(negedge clk);
      start = 1'b0;
    end
    wait_finish(f0, 200 + 80 * n);
    @(negedge clk);
    chk("busy_after_run", 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, k;
    reset = 1'b1; start = 1'b0; base = '0; num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdi", 32'(sdi), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_prime_count", 32'(prime_count), 32'd0);
    chk("rst_last_prime", 32'(last_prime), 32'd0);
    @(negedge clk) reset = 1'b0;

    run(8'hA5, 1, 1'b0);
    run(2, 9, 1'b0);
    run(8'hFE, 4, 1'b0);

    // Empty run: finished two edges after the start edge, cs untouched.
    expect_run(8'h33, 0);
    @(negedge clk);
    base = 8'h33; num = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_busy_t1", 32'(busy), 32'd1);
    chk("empty_fin_t1", 32'(finished), 32'd0);
    chk("empty_cs_t1", 32'(cs), 32'd1);
    @(negedge clk);
    chk("empty_fin_t2", 32'(finished), 32'd1);
    chk("empty_busy_t2", 32'(busy), 32'd0);
    chk("empty_cs_t2", 32'(cs), 32'd1);
    @(negedge clk);

    run(8'h1D, 4, 1'b1);
    for (int r = 0; r < 3; r++)
      run(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b0);

    // Abort during the 4th bit of the second word.
    expect_run(8'h0B, 3);
    w0 = mon_words;
    @(negedge clk);
    base = 8'h0B; num = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mon_words == w0 + 1 && rx_bits == 3) && k < 600) begin
      @(posedge clk);
      k++;
    end
    if (k >= 600) begin
      vectors++; miscompares++;
      $display("FAIL abort_point_timeout: got no 4th bit, want it within 600 cycles");
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_prime_count", 32'(prime_count), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    @(negedge clk);
    cand_q.delete();
    res_q.delete();
    model_last = 0;
    @(negedge clk) reset = 1'b0;

    run(8'h0B, 3, 1'b0);

    repeat (5) @(negedge clk);
    chk("words_left", cand_q.size(), 0);
    chk("results_left", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
